// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for the load-use hazard / stall controller.
// The pipeline drives through the master modport, the controller sits on slave.
interface hazard_stall_ctrl_if #(
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STALL_CNT_W    = 16
);
  logic [INST_WIDTH-1:0]     id_instruction;
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_mem_rd;
  logic                      ex_valid;
  logic                      mem_ready;
  logic                      flush;

  logic                      pc_dis;
  logic                      if_id_hold;
  logic                      id_ex_bubble;
  logic                      pipe_freeze;
  logic [STALL_CNT_W-1:0]    stall_cnt;

  modport master (
    output id_instruction, id_valid, ex_rd_addr, ex_mem_rd, ex_valid,
           mem_ready, flush,
    input  pc_dis, if_id_hold, id_ex_bubble, pipe_freeze, stall_cnt
  );

  modport slave (
    input  id_instruction, id_valid, ex_rd_addr, ex_mem_rd, ex_valid,
           mem_ready, flush,
    output pc_dis, if_id_hold, id_ex_bubble, pipe_freeze, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard and stall controller for the rrv RV32I five-stage pipeline.
// A per-register scoreboard remembers loads that have left EX but whose data
// is not yet forwardable, so a multi-cycle data memory (LOAD_LAT) yields the
// right number of bubbles. Memory back-pressure freezes the whole pipe and
// takes priority over a branch flush, which in turn overrides a hazard stall.
module hazard_stall_ctrl #(
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LAT       = 1,
  parameter int STALL_CNT_W    = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int SB_W     = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  // A load leaving EX has already been covered for one cycle by the direct
  // EX compare, so the scoreboard only needs to cover the remaining cycles.
  localparam logic [SB_W-1:0] SB_RELOAD = SB_W'(LOAD_LAT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  logic [6:0]             opcode;
  reg_addr_t              rs1;
  reg_addr_t              rs2;
  logic                   use_rs1;
  logic                   use_rs2;
  logic                   load_in_ex;
  logic                   rs1_busy;
  logic                   rs2_busy;
  logic                   hazard;
  logic                   stall_take;
  logic [SB_W-1:0]        sb_q [NUM_REGS];
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   unused_instr_bits;

  assign opcode = bus.id_instruction[6:0];
  assign rs1    = bus.id_instruction[15 +: REG_ADDR_WIDTH];
  assign rs2    = bus.id_instruction[20 +: REG_ADDR_WIDTH];

  // funct/imm/rd fields play no part in source-register decode
  assign unused_instr_bits = ^{bus.id_instruction[INST_WIDTH-1:20+REG_ADDR_WIDTH],
                               bus.id_instruction[14:7]};

  // Which source fields the instruction in ID actually reads.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Loads to x0 are discarded by the register file, so they never block.
  assign load_in_ex = bus.ex_valid & bus.ex_mem_rd & (bus.ex_rd_addr != '0);

  assign rs1_busy = (rs1 != '0) &&
                    ((load_in_ex && (rs1 == bus.ex_rd_addr)) || (sb_q[rs1] != '0));
  assign rs2_busy = (rs2 != '0) &&
                    ((load_in_ex && (rs2 == bus.ex_rd_addr)) || (sb_q[rs2] != '0));

  assign hazard = bus.id_valid & ((use_rs1 & rs1_busy) | (use_rs2 & rs2_busy));

  // A cycle counts as a load-use stall only when neither freeze nor flush wins.
  assign stall_take = rst_n & bus.mem_ready & ~bus.flush & hazard;

  // Scoreboard: reload on a load leaving EX, otherwise count down; hold on freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= '0;
    end else if (bus.mem_ready) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_in_ex && (bus.ex_rd_addr == reg_addr_t'(i))) begin
          sb_q[i] <= SB_RELOAD;
        end else if (sb_q[i] != '0) begin
          sb_q[i] <= sb_q[i] - 1'b1;
        end
      end
    end
  end

  // Prioritised control outputs; everything is held low while in reset.
  always_comb begin
    bus.pc_dis       = 1'b0;
    bus.if_id_hold   = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.pipe_freeze  = 1'b0;
    if (rst_n) begin
      if (!bus.mem_ready) begin
        bus.pipe_freeze = 1'b1;
        bus.pc_dis      = 1'b1;
        bus.if_id_hold  = 1'b1;
      end else if (bus.flush) begin
        bus.id_ex_bubble = 1'b1;
      end else if (hazard) begin
        bus.pc_dis       = 1'b1;
        bus.if_id_hold   = 1'b1;
        bus.id_ex_bubble = 1'b1;
      end
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_take && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3,
// LOAD_LAT=1 with a 4-bit counter) share clock and reset.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // expected {pc_dis, if_id_hold, id_ex_bubble, pipe_freeze}
  localparam logic [3:0] S = 4'b1110;
  localparam logic [3:0] F = 4'b1101;
  localparam logic [3:0] K = 4'b0010;
  localparam logic [3:0] Z = 4'b0000;

  typedef struct packed {
    logic [31:0] instr;
    logic        id_valid;
    logic [4:0]  ex_rd;
    logic        ex_ld;
    logic        ex_valid;
    logic        mem_ready;
    logic        flush;
  } in_t;

  typedef struct {
    in_t        in;
    logic [3:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  in_t         drv [3];
  logic [3:0]  got [3];
  logic [15:0] cnt [3];

  hazard_stall_ctrl_if #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .STALL_CNT_W(16)) if_a ();
  hazard_stall_ctrl_if #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .STALL_CNT_W(16)) if_b ();
  hazard_stall_ctrl_if #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .STALL_CNT_W(4))  if_c ();

  hazard_stall_ctrl #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_LAT(1), .STALL_CNT_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  hazard_stall_ctrl #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_LAT(3), .STALL_CNT_W(16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  hazard_stall_ctrl #(.INST_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_LAT(1), .STALL_CNT_W(4))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.id_instruction = drv[0].instr;
  assign if_a.id_valid       = drv[0].id_valid;
  assign if_a.ex_rd_addr     = drv[0].ex_rd;
  assign if_a.ex_mem_rd      = drv[0].ex_ld;
  assign if_a.ex_valid       = drv[0].ex_valid;
  assign if_a.mem_ready      = drv[0].mem_ready;
  assign if_a.flush          = drv[0].flush;
  assign if_b.id_instruction = drv[1].instr;
  assign if_b.id_valid       = drv[1].id_valid;
  assign if_b.ex_rd_addr     = drv[1].ex_rd;
  assign if_b.ex_mem_rd      = drv[1].ex_ld;
  assign if_b.ex_valid       = drv[1].ex_valid;
  assign if_b.mem_ready      = drv[1].mem_ready;
  assign if_b.flush          = drv[1].flush;
  assign if_c.id_instruction = drv[2].instr;
  assign if_c.id_valid       = drv[2].id_valid;
  assign if_c.ex_rd_addr     = drv[2].ex_rd;
  assign if_c.ex_mem_rd      = drv[2].ex_ld;
  assign if_c.ex_valid       = drv[2].ex_valid;
  assign if_c.mem_ready      = drv[2].mem_ready;
  assign if_c.flush          = drv[2].flush;

  assign got[0] = {if_a.pc_dis, if_a.if_id_hold, if_a.id_ex_bubble, if_a.pipe_freeze};
  assign got[1] = {if_b.pc_dis, if_b.if_id_hold, if_b.id_ex_bubble, if_b.pipe_freeze};
  assign got[2] = {if_c.pc_dis, if_c.if_id_hold, if_c.id_ex_bubble, if_c.pipe_freeze};
  assign cnt[0] = if_a.stall_cnt;
  assign cnt[1] = if_b.stall_cnt;
  assign cnt[2] = 16'(if_c.stall_cnt);

  function automatic logic [31:0] ins(logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, 5'd1, op};
  endfunction

  function automatic in_t iv(logic [31:0] i, logic idv, logic [4:0] rd, logic ld,
                             logic exv, logic rdy, logic fl);
    in_t v;
    v.instr = i; v.id_valid = idv; v.ex_rd = rd; v.ex_ld = ld;
    v.ex_valid = exv; v.mem_ready = rdy; v.flush = fl;
    return v;
  endfunction

  function automatic vec_t mkv(in_t i, logic [3:0] e);
    vec_t v;
    v.in = i; v.exp = e;
    return v;
  endfunction

  task automatic chk(input logic [31:0] actual, input logic [31:0] expected, input string nm);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, actual, expected);
    end
  endtask

  // One clock cycle on one instance: drive, compare outputs mid-cycle, advance.
  task automatic cyc(input int sel, input in_t v, input logic [3:0] e, input string nm);
    drv[sel] = v;
    @(negedge clk);
    chk(32'(got[sel]), 32'(e), nm);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [22];
  in_t  idle;
  logic [31:0] add6;

  initial begin
    idle = iv(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    add6 = ins(OP_R, 5'd6, 5'd30);

    // load x5 in EX against each opcode class in ID; LOAD_LAT=1 leaves no residue
    tbl[0]  = mkv(iv(ins(OP_R, 5'd5, 5'd6),      1, 5, 1, 1, 1, 0), S);
    tbl[1]  = mkv(iv(ins(OP_R, 5'd6, 5'd5),      1, 5, 1, 1, 1, 0), S);
    tbl[2]  = mkv(iv(ins(OP_R, 5'd6, 5'd7),      1, 5, 1, 1, 1, 0), Z);
    tbl[3]  = mkv(iv(ins(OP_STORE, 5'd9, 5'd5),  1, 5, 1, 1, 1, 0), S);
    tbl[4]  = mkv(iv(ins(OP_BRANCH, 5'd5, 5'd0), 1, 5, 1, 1, 1, 0), S);
    tbl[5]  = mkv(iv(ins(OP_IMM, 5'd5, 5'd0),    1, 5, 1, 1, 1, 0), S);
    tbl[6]  = mkv(iv(ins(OP_IMM, 5'd6, 5'd5),    1, 5, 1, 1, 1, 0), Z);
    tbl[7]  = mkv(iv(ins(OP_LOAD, 5'd5, 5'd0),   1, 5, 1, 1, 1, 0), S);
    tbl[8]  = mkv(iv(ins(OP_JALR, 5'd5, 5'd0),   1, 5, 1, 1, 1, 0), S);
    tbl[9]  = mkv(iv(ins(OP_LUI, 5'd5, 5'd5),    1, 5, 1, 1, 1, 0), Z);
    tbl[10] = mkv(iv(ins(OP_AUIPC, 5'd5, 5'd5),  1, 5, 1, 1, 1, 0), Z);
    tbl[11] = mkv(iv(ins(OP_JAL, 5'd5, 5'd5),    1, 5, 1, 1, 1, 0), Z);
    tbl[12] = mkv(iv(ins(OP_SYS, 5'd5, 5'd5),    1, 5, 1, 1, 1, 0), Z);
    tbl[13] = mkv(iv(ins(OP_FENCE, 5'd5, 5'd5),  1, 5, 1, 1, 1, 0), Z);
    tbl[14] = mkv(iv(ins(OP_R, 5'd5, 5'd6),      0, 5, 1, 1, 1, 0), Z);
    tbl[15] = mkv(iv(ins(OP_R, 5'd5, 5'd6),      1, 5, 0, 1, 1, 0), Z);
    tbl[16] = mkv(iv(ins(OP_R, 5'd5, 5'd6),      1, 5, 1, 0, 1, 0), Z);
    tbl[17] = mkv(iv(ins(OP_R, 5'd0, 5'd0),      1, 0, 1, 1, 1, 0), Z);
    tbl[18] = mkv(iv(ins(OP_R, 5'd5, 5'd6),      1, 5, 1, 1, 0, 0), F);
    tbl[19] = mkv(iv(ins(OP_R, 5'd5, 5'd6),      1, 5, 1, 1, 1, 1), K);
    tbl[20] = mkv(iv(ins(OP_R, 5'd1, 5'd2),      1, 5, 1, 1, 1, 1), K);
    tbl[21] = mkv(iv(ins(OP_R, 5'd1, 5'd2),      1, 5, 1, 1, 0, 0), F);

    // reset state, with hazard and freeze stimulus applied during reset
    drv[0] = iv(add6, 1, 6, 1, 1, 1, 0);
    drv[1] = iv(add6, 1, 6, 1, 1, 0, 0);
    drv[2] = iv(add6, 1, 6, 1, 1, 1, 1);
    #3;
    for (int i = 0; i < 3; i++) begin
      chk(32'(got[i]), 32'(Z), "reset_outputs");
      chk(32'(cnt[i]), 32'd0, "reset_stall_cnt");
    end
    for (int i = 0; i < 3; i++) drv[i] = idle;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD_LAT=1 basic pair, then the decode/priority table
    cyc(0, iv(add6, 1, 6, 1, 1, 1, 0), S, "lat1_stall");
    cyc(0, iv(add6, 1, 0, 0, 0, 1, 0), Z, "lat1_release");
    chk(32'(cnt[0]), 32'd1, "lat1_cnt");
    for (int i = 0; i < 22; i++) cyc(0, tbl[i].in, tbl[i].exp, $sformatf("table_%0d", i));
    drv[0] = idle;
    chk(32'(cnt[0]), 32'd8, "table_cnt");

    // 4-bit counter saturation
    for (int k = 0; k < 20; k++) begin
      cyc(2, iv(add6, 1, 6, 1, 1, 1, 0), S, "sat_stall");
      if (k == 13) chk(32'(cnt[2]), 32'd14, "sat_cnt_14");
    end
    drv[2] = idle;
    chk(32'(cnt[2]), 32'd15, "sat_cnt_15");

    // LOAD_LAT=3 adjacent consumer: three stalls
    cyc(1, iv(add6, 1, 6, 1, 1, 1, 0), S, "lat3_s1");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), S, "lat3_s2");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), S, "lat3_s3");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), Z, "lat3_release");
    chk(32'(cnt[1]), 32'd3, "lat3_cnt");
    cyc(1, iv(ins(OP_R, 5'd2, 5'd3), 1, 6, 1, 1, 1, 0), Z, "lat3_indep");
    cyc(1, idle, Z, "idle");
    cyc(1, idle, Z, "idle");

    // distance 2 store consumer: two stalls
    cyc(1, iv(ins(OP_R, 5'd2, 5'd3), 1, 5, 1, 1, 1, 0), Z, "d2_gap");
    cyc(1, iv(ins(OP_STORE, 5'd9, 5'd5), 1, 1, 0, 1, 1, 0), S, "d2_s1");
    cyc(1, iv(ins(OP_STORE, 5'd9, 5'd5), 1, 0, 0, 0, 1, 0), S, "d2_s2");
    cyc(1, iv(ins(OP_STORE, 5'd9, 5'd5), 1, 0, 0, 0, 1, 0), Z, "d2_release");
    chk(32'(cnt[1]), 32'd5, "d2_cnt");

    // lui x5 as the consumer never stalls
    cyc(1, iv(ins(OP_R, 5'd2, 5'd3), 1, 5, 1, 1, 1, 0), Z, "lui_gap");
    cyc(1, iv(ins(OP_LUI, 5'd5, 5'd5), 1, 1, 0, 1, 1, 0), Z, "lui_nostall");
    cyc(1, idle, Z, "idle");
    cyc(1, idle, Z, "idle");
    chk(32'(cnt[1]), 32'd5, "lui_cnt");

    // freeze in the middle of a stall holds scoreboard and counter
    cyc(1, iv(add6, 1, 6, 1, 1, 1, 0), S, "frz_pre");
    for (int k = 0; k < 4; k++) cyc(1, iv(add6, 1, 0, 0, 0, 0, 0), F, "frz_hold");
    chk(32'(cnt[1]), 32'd6, "frz_cnt_hold");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), S, "frz_resume1");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), S, "frz_resume2");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), Z, "frz_release");
    chk(32'(cnt[1]), 32'd8, "frz_cnt");

    // flush beats hazard, but the load is still tracked
    cyc(1, iv(add6, 1, 6, 1, 1, 1, 1), K, "flush_hazard");
    chk(32'(cnt[1]), 32'd8, "flush_cnt");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), S, "flush_sb1");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), S, "flush_sb2");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), Z, "flush_sb_release");

    // load to x0 never stalls
    cyc(1, iv(ins(OP_R, 5'd0, 5'd0), 1, 0, 1, 1, 1, 0), Z, "x0_ex");
    cyc(1, iv(ins(OP_R, 5'd0, 5'd0), 1, 0, 0, 0, 1, 0), Z, "x0_sb");

    // a newer load to the same rd restarts its countdown
    cyc(1, iv(ins(OP_R, 5'd2, 5'd3), 1, 7, 1, 1, 1, 0), Z, "restart_ld1");
    cyc(1, iv(ins(OP_R, 5'd2, 5'd3), 1, 7, 1, 1, 1, 0), Z, "restart_ld2");
    cyc(1, iv(ins(OP_R, 5'd7, 5'd3), 1, 0, 0, 0, 1, 0), S, "restart_s1");
    cyc(1, iv(ins(OP_R, 5'd7, 5'd3), 1, 0, 0, 0, 1, 0), S, "restart_s2");
    cyc(1, iv(ins(OP_R, 5'd7, 5'd3), 1, 0, 0, 0, 1, 0), Z, "restart_release");
    chk(32'(cnt[1]), 32'd12, "restart_cnt");

    // reset in the middle of a stall
    cyc(1, iv(add6, 1, 6, 1, 1, 1, 0), S, "rst_pre");
    drv[1] = iv(add6, 1, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk(32'(got[1]), 32'(S), "rst_mid_stall");
    #2;
    rst_n = 1'b0;
    #1;
    chk(32'(got[1]), 32'(Z), "rst_outputs_drop");
    chk(32'(cnt[1]), 32'd0, "rst_cnt_b");
    chk(32'(cnt[0]), 32'd0, "rst_cnt_a");
    chk(32'(cnt[2]), 32'd0, "rst_cnt_c");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), Z, "post_rst1");
    cyc(1, iv(add6, 1, 0, 0, 0, 1, 0), Z, "post_rst2");
    chk(32'(cnt[1]), 32'd0, "post_rst_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
